serial_subtractor: RTL and testbench

//  Multi-cycle bit-serial subtractor computing DIFF = A - B, LSB first, one bit per clock.

---
 rtl/serial_subtractor_pkg.sv | 13 +
 rtl/serial_subtractor_full_subtractor.sv | 21 ++
 rtl/serial_subtractor.sv | 100 ++++++++++
 tb/tb_serial_subtractor.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/serial_subtractor_pkg.sv
// Shared arithmetic definitions: FSM state encodings and the default operand
// width used by the bit-serial arithmetic blocks.
package serial_subtractor_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef logic [1:0] state_t;

  localparam logic [1:0] S_IDLE  = 2'b00;
  localparam logic [1:0] S_SHIFT = 2'b01;
  localparam logic [1:0] S_DONE  = 2'b10;

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// Combinational full-subtractor cell (x - y - bin), built from two
// cascaded half-subtractors.
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  logic w_d1;
  logic w_b1;
  logic w_b2;

  assign w_d1 = x ^ y;
  assign w_b1 = ~x & y;
  assign d    = w_d1 ^ bin;
  assign w_b2 = ~w_d1 & bin;
  assign bout = w_b1 | w_b2;

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b, LSB first, one bit per clock, with a
// registered borrow and a start/busy/done handshake.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic [1:0]       dbg_state
);

  // Handshake: start is accepted on any edge where busy==0 (IDLE or DONE),
  // and a/b are captured on that same edge. busy stays high for exactly WIDTH
  // cycles, then done pulses for one cycle with diff/borrow_out valid.
  // start seen while busy is ignored.

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t             r_state;
  logic [WIDTH-1:0]   r_a_sr;
  logic [WIDTH-1:0]   r_b_sr;
  logic [WIDTH-2:0]   r_d_sr;
  logic               r_bw;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_diff;
  logic               r_borrow_out;

  logic               w_d;
  logic               w_bout;
  logic [WIDTH-1:0]   w_d_next;

  full_subtractor u_cell (
    .x    (r_a_sr[0]),
    .y    (r_b_sr[0]),
    .bin  (r_bw),
    .d    (w_d),
    .bout (w_bout)
  );

  // Only WIDTH-1 result bits need storage; the final bit arrives combinationally
  // on the completing edge and goes straight into diff.
  assign w_d_next = {w_d, r_d_sr};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_a_sr       <= '0;
      r_b_sr       <= '0;
      r_d_sr       <= '0;
      r_bw         <= 1'b0;
      r_cnt        <= '0;
      r_diff       <= '0;
      r_borrow_out <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_a_sr  <= a;
            r_b_sr  <= b;
            r_d_sr  <= '0;
            r_bw    <= 1'b0;
            r_cnt   <= '0;
            r_state <= S_SHIFT;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_SHIFT: begin
          r_a_sr <= {1'b0, r_a_sr[WIDTH-1:1]};
          r_b_sr <= {1'b0, r_b_sr[WIDTH-1:1]};
          r_d_sr <= w_d_next[WIDTH-1:1];
          r_bw   <= w_bout;
          r_cnt  <= r_cnt + CNT_W'(1);
          if (r_cnt == CNT_LAST) begin
            r_diff       <= w_d_next;
            r_borrow_out <= w_bout;
            r_state      <= S_DONE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy       = (r_state == S_SHIFT);
  assign done       = (r_state == S_DONE);
  assign diff       = r_diff;
  assign borrow_out = r_borrow_out;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed cases plus random
// operations scored against an unsigned A-B reference model.
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         borrow_out;
  logic [1:0]   dbg_state;

  int           n_checks;
  int           n_errors;
  int           cyc;

  logic [W:0]   exp_q[$];
  logic [W:0]   held;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .a          (a),
    .b          (b),
    .busy       (busy),
    .done       (done),
    .diff       (diff),
    .borrow_out (borrow_out),
    .dbg_state  (dbg_state)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc++;

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Reference model: borrow is bit W of the (W+1)-bit unsigned difference.
  function automatic logic [W:0] model_sub(input logic [W-1:0] x, input logic [W-1:0] y);
    return {1'b0, x} - {1'b0, y};
  endfunction

  // Scoreboard / monitor
  always @(negedge clk) begin
    if (rst_n) begin
      check_value("busy_done_excl", {31'b0, busy & done}, 32'h0);
      if (done) begin
        if (exp_q.size() == 0) begin
          check_value("unexpected_done", 32'h1, 32'h0);
        end else begin
          held = exp_q.pop_front();
          check_value("result", {23'b0, borrow_out, diff}, {23'b0, held});
        end
      end else begin
        check_value("result_hold", {23'b0, borrow_out, diff}, {23'b0, held});
      end
    end
  end

  // Drivers
  task automatic wait_done(output int at_cyc);
    at_cyc = -1;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      if (done) begin
        at_cyc = cyc;
        break;
      end
    end
    if (at_cyc < 0) check_value("done_timeout", 32'h0, 32'h1);
  endtask

  task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y);
    int s_cyc;
    int d_cyc;
    @(posedge clk);
    #2;
    start = 1'b1;
    a     = x;
    b     = y;
    exp_q.push_back(model_sub(x, y));
    s_cyc = cyc;
    @(posedge clk);
    #2;
    start = 1'b0;
    a     = W'($urandom);
    b     = W'($urandom);
    wait_done(d_cyc);
    if (d_cyc >= 0) check_value("latency", d_cyc - s_cyc, 32'd9);
  endtask

  initial begin
    int d1;
    int d2;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    n_checks = 0;
    n_errors = 0;
    cyc      = 0;
    held     = '0;
    start    = 1'b0;
    a        = '0;
    b        = '0;
    rst_n    = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check_value("rst_busy", {31'b0, busy}, 32'h0);
    check_value("rst_done", {31'b0, done}, 32'h0);
    check_value("rst_diff", {24'b0, diff}, 32'h0);
    check_value("rst_borrow", {31'b0, borrow_out}, 32'h0);
    check_value("rst_state", {30'b0, dbg_state}, 32'h0);
    rst_n = 1'b1;

    // T1-T3 directed values
    run_op(8'h05, 8'h03);
    run_op(8'h03, 8'h05);
    run_op(8'h00, 8'h01);
    run_op(8'hFF, 8'hFF);

    // T4: start held high, operands changed mid-operation, back-to-back op
    @(posedge clk);
    #2;
    start = 1'b1;
    a     = 8'hA5;
    b     = 8'h3C;
    exp_q.push_back(model_sub(8'hA5, 8'h3C));
    exp_q.push_back(model_sub(8'h11, 8'h22));
    repeat (3) @(posedge clk);
    #2;
    a = 8'h11;
    b = 8'h22;
    wait_done(d1);
    @(posedge clk);
    #2;
    start = 1'b0;
    check_value("b2b_busy", {31'b0, busy}, 32'h1);
    wait_done(d2);
    if (d1 >= 0 && d2 >= 0) check_value("b2b_period", d2 - d1, 32'd9);

    // T5: reset during SHIFT cycle 4
    @(posedge clk);
    #2;
    start = 1'b1;
    a     = 8'h12;
    b     = 8'h34;
    @(posedge clk);
    #2;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_value("mid_rst_busy", {31'b0, busy}, 32'h0);
    check_value("mid_rst_done", {31'b0, done}, 32'h0);
    check_value("mid_rst_diff", {24'b0, diff}, 32'h0);
    check_value("mid_rst_borrow", {31'b0, borrow_out}, 32'h0);
    held = '0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    repeat (12) @(posedge clk);
    run_op(8'h80, 8'h01);

    // T6: random operations with equal and zero-subtrahend corner cases
    for (int i = 0; i < 1000; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      case ($urandom_range(0, 7))
        0: rb = ra;
        1: rb = '0;
        default: ;
      endcase
      run_op(ra, rb);
    end

    repeat (4) @(posedge clk);
    check_value("queue_empty", exp_q.size(), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
